// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: program-load memory, next-PC select and IF/ID register.
// Define IF_HALT_DETECT_EN to stop fetching on an all-ones opcode (HALT state).
module if_fetch_stage #(
    parameter  int N_BITS    = 32,
    parameter  int MEM_DEPTH = 64,
    localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [N_BITS-1:0] i_pc,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_branch_taken,
    input  logic [N_BITS-1:0] i_branch_addr,
    input  logic              i_jump,
    input  logic [N_BITS-1:0] i_jump_addr,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [N_BITS-1:0] i_wr_data,
    output logic [N_BITS-1:0] o_next_address,
    output logic              o_pc_valid,
    output logic [N_BITS-1:0] o_instr,
    output logic [N_BITS-1:0] o_pc_plus4,
    output logic              o_if_valid,
    output logic              o_halted
);

`ifdef IF_HALT_DETECT_EN
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
`else
    typedef enum logic [0:0] {IDLE, RUN} state_t;
`endif

    state_t state_q, state_d;

    logic [N_BITS-1:0] mem [MEM_DEPTH];
    logic [N_BITS-1:0] fetched;
    logic [N_BITS-1:0] pc_plus4;
    logic              pc_out_of_range;
    logic              load_en;
    logic              halt_detect;
    logic              unused_pc_low;

    assign unused_pc_low   = ^i_pc[1:0];
    assign pc_plus4        = i_pc + N_BITS'(4);
    assign pc_out_of_range = |i_pc[N_BITS-1:ADDR_W+2];
    assign fetched         = pc_out_of_range ? '0 : mem[i_pc[ADDR_W+1:2]];
    assign load_en         = (state_q == RUN) && !i_flush && !i_stall;

`ifdef IF_HALT_DETECT_EN
    assign halt_detect = load_en && (fetched[31:26] == 6'b111111);
    assign o_halted    = (state_q == HALT);
`else
    assign halt_detect = 1'b0;
    assign o_halted    = 1'b0;
`endif

    // Program loading is only allowed before fetching starts; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset && state_q == IDLE && i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (i_start) state_d = RUN;
`ifdef IF_HALT_DETECT_EN
            RUN:  if (halt_detect) state_d = HALT;
`else
            RUN:  if (halt_detect) state_d = RUN;
`endif
            default: state_d = state_q;
        endcase
    end

    // Jump outranks branch; a redirect must reach the PC even while stalled.
    always_comb begin
        o_next_address = pc_plus4;
        if (i_jump) begin
            o_next_address = i_jump_addr;
        end else if (i_branch_taken) begin
            o_next_address = i_branch_addr;
        end
        o_pc_valid = (state_q == RUN) && (i_jump || i_branch_taken || !i_stall);
    end

    // IF/ID register: flush beats stall; outside RUN only the valid bit drops.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            o_instr    <= '0;
            o_pc_plus4 <= '0;
            o_if_valid <= 1'b0;
        end else if (load_en) begin
            o_instr    <= fetched;
            o_pc_plus4 <= pc_plus4;
            o_if_valid <= 1'b1;
        end else if (state_q != RUN) begin
            o_if_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the fetch stage.
module tb_if_fetch_stage;

`ifdef IF_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, stall, flush, branch, jump, wr_en;
    logic [31:0] pc, baddr, jaddr, wr_data;
    logic [5:0]  wr_addr;
    logic [31:0] o_next_address, o_instr, o_pc_plus4;
    logic        o_pc_valid, o_if_valid, o_halted;

    int checks = 0;
    int errors = 0;

    // Model: memory image, mode (0 idle, 1 run, 2 halted) and IF/ID contents
    logic [31:0] m_mem [64];
    int          m_state;
    logic [31:0] m_instr, m_p4;
    logic        m_valid;

    always #5 clk = ~clk;

    if_fetch_stage #(.N_BITS(32), .MEM_DEPTH(64)) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_pc(pc),
        .i_stall(stall), .i_flush(flush),
        .i_branch_taken(branch), .i_branch_addr(baddr),
        .i_jump(jump), .i_jump_addr(jaddr),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .o_next_address(o_next_address), .o_pc_valid(o_pc_valid),
        .o_instr(o_instr), .o_pc_plus4(o_pc_plus4),
        .o_if_valid(o_if_valid), .o_halted(o_halted)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] modelFetch(input logic [31:0] addr);
        if (addr >= 32'd256) return 32'd0;
        return m_mem[(addr / 4) % 64];
    endfunction

    task automatic clearInputs();
        rst = 0; start = 0; stall = 0; flush = 0; branch = 0; jump = 0;
        wr_en = 0; pc = 0; baddr = 0; jaddr = 0; wr_addr = 0; wr_data = 0;
    endtask

    // One clock: check combinational outputs mid-cycle, advance model, check IF/ID
    task automatic applyStimulus();
        logic [31:0] exp_next, word;
        int          nxt;
        @(negedge clk);
        exp_next = jump ? jaddr : (branch ? baddr : pc + 32'd4);
        checkOutput("next_address", o_next_address, exp_next);
        checkOutput("pc_valid", {31'b0, o_pc_valid},
                    {31'b0, (m_state == 1) && (jump || branch || !stall)});
        checkOutput("halted", {31'b0, o_halted}, {31'b0, m_state == 2});
        @(posedge clk);
        if (rst) begin
            m_state = 0; m_instr = 0; m_p4 = 0; m_valid = 0;
        end else begin
            nxt  = m_state;
            word = modelFetch(pc);
            if (m_state == 0 && wr_en) m_mem[wr_addr] = wr_data;
            if (flush) begin
                m_instr = 0; m_p4 = 0; m_valid = 0;
            end else if (m_state == 1 && !stall) begin
                m_instr = word; m_p4 = pc + 32'd4; m_valid = 1;
                if (HALT_EN && (word >> 26) == 32'd63) nxt = 2;
            end else if (m_state != 1) begin
                m_valid = 0;
            end
            if (m_state == 0 && start) nxt = 1;
            m_state = nxt;
        end
        #1;
        checkOutput("instr", o_instr, m_instr);
        checkOutput("pc_plus4", o_pc_plus4, m_p4);
        checkOutput("if_valid", {31'b0, o_if_valid}, {31'b0, m_valid});
    endtask

    task automatic resetAndStart();
        clearInputs(); rst = 1; applyStimulus();
        rst = 0; start = 1; applyStimulus();
        start = 0;
    endtask

    initial begin
        clearInputs();
        rst = 1;
        for (int i = 0; i < 64; i++) m_mem[i] = 0;
        m_state = 0; m_instr = 0; m_p4 = 0; m_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus();
        checkOutput("reset_instr", o_instr, 32'd0);

        // Program load in IDLE; random filler never carries the halt opcode
        rst = 0;
        for (int i = 0; i < 64; i++) begin
            wr_en = 1; wr_addr = 6'(i);
            wr_data = (i == 0) ? 32'h20010005 : (i == 1) ? 32'h20020007 :
                      (i == 2) ? 32'hFC000000 : ($urandom & 32'hF7FF_FFFF);
            applyStimulus();
        end
        clearInputs();

        // Straight-line program ending in the halt word
        resetAndStart();
        pc = 32'h0; applyStimulus();
        checkOutput("seq_instr0", o_instr, 32'h20010005);
        pc = 32'h4; applyStimulus();
        checkOutput("seq_p4_1", o_pc_plus4, 32'h8);
        pc = 32'h8; applyStimulus();
        checkOutput("seq_instr2", o_instr, 32'hFC000000);
        checkOutput("seq_p4_2", o_pc_plus4, 32'hC);
        pc = 32'hC; applyStimulus();
        checkOutput("seq_halted", {31'b0, o_halted}, {31'b0, HALT_EN});

        // Stall holds IF/ID and suppresses the PC update
        resetAndStart();
        pc = 32'h10; applyStimulus();
        stall = 1; applyStimulus(); applyStimulus();
        checkOutput("stall_held_p4", o_pc_plus4, 32'h14);
        stall = 0; applyStimulus();
        checkOutput("stall_release_p4", o_pc_plus4, 32'h14);

        // Jump beats branch, redirect beats stall
        pc = 32'h8; branch = 1; jump = 1; jaddr = 32'h40; baddr = 32'h20; stall = 1;
        @(negedge clk);
        checkOutput("redirect_addr", o_next_address, 32'h40);
        checkOutput("redirect_valid", {31'b0, o_pc_valid}, 32'd1);
        applyStimulus();
        clearInputs();

        // Flush beats stall
        pc = 32'h4; applyStimulus();
        flush = 1; stall = 1; applyStimulus();
        checkOutput("flush_instr", o_instr, 32'd0);
        checkOutput("flush_valid", {31'b0, o_if_valid}, 32'd0);
        clearInputs();

        // Writes ignored while running; out-of-range PC fetches a NOP
        wr_en = 1; wr_addr = 0; wr_data = 32'hDEADBEEF; pc = 32'h0; applyStimulus();
        wr_en = 0; applyStimulus();
        checkOutput("run_write_ignored", o_instr, 32'h20010005);
        pc = 32'h1000; applyStimulus();
        checkOutput("oob_instr", o_instr, 32'd0);

        // Reset wins over a same-cycle write, both mid-RUN and in IDLE
        pc = 32'h4; rst = 1; wr_en = 1; wr_addr = 1; wr_data = 32'hDEADBEEF;
        applyStimulus();
        checkOutput("midrun_reset_p4", o_pc_plus4, 32'd0);
        applyStimulus();
        rst = 0; wr_en = 0; start = 1; applyStimulus();
        start = 0; pc = 32'h4; applyStimulus();
        checkOutput("reset_write_blocked", o_instr, 32'h20020007);

        // Randomized traffic
        clearInputs();
        for (int n = 0; n < 400; n++) begin
            rst    = ($urandom_range(0, 99) < 3) || (m_state == 2 && $urandom_range(0, 3) == 0);
            start  = 1'($urandom_range(0, 1));
            stall  = $urandom_range(0, 9) < 3;
            flush  = $urandom_range(0, 9) < 1;
            branch = $urandom_range(0, 9) < 2;
            jump   = $urandom_range(0, 19) < 3;
            baddr  = $urandom;
            jaddr  = $urandom;
            pc     = ($urandom_range(0, 19) == 0) ? $urandom
                     : ((32'($urandom_range(0, 70)) << 2) | 32'($urandom_range(0, 3)));
            wr_en   = $urandom_range(0, 3) == 0;
            wr_addr = 6'($urandom_range(0, 63));
            wr_data = $urandom & 32'hF7FF_FFFF;
            applyStimulus();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
